// File: rtl/menshen_phv_pkg.sv
// Shared constants for the PHV queue merger: channel count, queue field placement and counter widths.
package menshen_phv_pkg;

    localparam int C_NUM_QUEUES   = 4;
    localparam int QUEUE_BIT_OFF  = 141;
    localparam int QUEUE_FIELD_W  = 4;
    localparam int QUEUE_ID_W     = 2;
    localparam int DROP_CNT_W     = 16;

    typedef logic [QUEUE_ID_W-1:0] queue_id_t;

endpackage

// File: rtl/phv_sync_fifo.sv
// Single-clock PHV FIFO with combinational head read and a free-entry count for early ready.
module phv_sync_fifo #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = CW'(DEPTH) - count;

endmodule

// File: rtl/phv_queue_merger.sv
// Merges four per-queue PHV streams into one through per-channel FIFOs, a round-robin arbiter
// and a single output register; overflowing writes are dropped and counted per channel.
module phv_queue_merger #(
    parameter int PHV_LEN       = 1024,
    parameter int C_NUM_QUEUES  = menshen_phv_pkg::C_NUM_QUEUES,
    parameter int FIFO_DEPTH    = 4,
    parameter int QUEUE_BIT_OFF = menshen_phv_pkg::QUEUE_BIT_OFF
) (
    input  logic                                   axis_clk,
    input  logic                                   areset,
    input  logic [PHV_LEN-1:0]                     phv_in_0,
    input  logic [PHV_LEN-1:0]                     phv_in_1,
    input  logic [PHV_LEN-1:0]                     phv_in_2,
    input  logic [PHV_LEN-1:0]                     phv_in_3,
    input  logic                                   phv_in_valid_0,
    input  logic                                   phv_in_valid_1,
    input  logic                                   phv_in_valid_2,
    input  logic                                   phv_in_valid_3,
    output logic                                   phv_fifo_ready_0,
    output logic                                   phv_fifo_ready_1,
    output logic                                   phv_fifo_ready_2,
    output logic                                   phv_fifo_ready_3,
    output logic [PHV_LEN-1:0]                     m_phv,
    output logic [menshen_phv_pkg::QUEUE_ID_W-1:0] m_queue_id,
    output logic                                   m_phv_valid,
    input  logic                                   m_phv_ready,
    output logic [menshen_phv_pkg::DROP_CNT_W-1:0] drop_cnt_0,
    output logic [menshen_phv_pkg::DROP_CNT_W-1:0] drop_cnt_1,
    output logic [menshen_phv_pkg::DROP_CNT_W-1:0] drop_cnt_2,
    output logic [menshen_phv_pkg::DROP_CNT_W-1:0] drop_cnt_3
);

    import menshen_phv_pkg::*;

    localparam int NQ     = 4;
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    if (C_NUM_QUEUES != NQ) begin : g_bad_nq
        $error("phv_queue_merger supports exactly 4 queues");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end
    if (QUEUE_BIT_OFF + QUEUE_FIELD_W > PHV_LEN) begin : g_bad_qoff
        $error("queue field lies outside the PHV");
    end

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [PHV_LEN-1:0] phv_in   [NQ];
    logic [PHV_LEN-1:0] fifo_out [NQ];
    logic [FREE_W-1:0]  free_cnt [NQ];
    logic [NQ-1:0]      vld_in;
    logic [NQ-1:0]      push;
    logic [NQ-1:0]      pop;
    logic [NQ-1:0]      drop;
    logic [NQ-1:0]      full;
    logic [NQ-1:0]      empty;
    logic [NQ-1:0]      fifo_ready;
    logic [DROP_CNT_W-1:0] drop_cnt [NQ];

    assign phv_in[0] = phv_in_0;
    assign phv_in[1] = phv_in_1;
    assign phv_in[2] = phv_in_2;
    assign phv_in[3] = phv_in_3;
    assign vld_in    = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

    queue_id_t          last_grant;
    queue_id_t          grant;
    queue_id_t          cand;
    logic               found;
    logic               load;
    logic [PHV_LEN-1:0] phv_p1;
    queue_id_t          qid_p1;
    logic               vld_p1;

    assign load = !areset && (|(~empty)) && (!vld_p1 || m_phv_ready);

    for (genvar k = 0; k < NQ; k++) begin : g_ch
        // A full FIFO still takes a write when the arbiter drains it on the same edge.
        assign pop[k]        = load && (grant == QUEUE_ID_W'(k));
        assign push[k]       = !areset && vld_in[k] && (!full[k] || pop[k]);
        assign drop[k]       = !areset && vld_in[k] && full[k] && !pop[k];
        assign fifo_ready[k] = (free_cnt[k] >= FREE_W'(2));

        phv_sync_fifo #(
            .DATA_W (PHV_LEN),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk      (axis_clk),
            .rst      (areset),
            .push     (push[k]),
            .pop      (pop[k]),
            .din      (phv_in[k]),
            .dout     (fifo_out[k]),
            .full     (full[k]),
            .empty    (empty[k]),
            .free_cnt (free_cnt[k])
        );

        logic [DROP_CNT_W-1:0] cnt;
        always_ff @(posedge axis_clk) begin
            if (areset)       cnt <= '0;
            else if (drop[k]) cnt <= sat_inc(cnt);
        end
        assign drop_cnt[k] = cnt;
    end

    // Round-robin: scan from the channel after the last grant.
    always_comb begin
        grant = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NQ; i++) begin
            cand = last_grant + QUEUE_ID_W'(i);
            if (!found && !empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            phv_p1     <= '0;
            qid_p1     <= '0;
            vld_p1     <= 1'b0;
            last_grant <= QUEUE_ID_W'(NQ - 1);
        end else if (load) begin
            phv_p1     <= fifo_out[grant];
            qid_p1     <= grant;
            vld_p1     <= 1'b1;
            last_grant <= grant;
        end else if (m_phv_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign m_phv       = phv_p1;
    assign m_queue_id  = qid_p1;
    assign m_phv_valid = vld_p1;

    assign phv_fifo_ready_0 = fifo_ready[0];
    assign phv_fifo_ready_1 = fifo_ready[1];
    assign phv_fifo_ready_2 = fifo_ready[2];
    assign phv_fifo_ready_3 = fifo_ready[3];
    assign drop_cnt_0       = drop_cnt[0];
    assign drop_cnt_1       = drop_cnt[1];
    assign drop_cnt_2       = drop_cnt[2];
    assign drop_cnt_3       = drop_cnt[3];

endmodule

// File: tb/tb_phv_queue_merger.sv
// Directed bench for phv_queue_merger: queue-based reference model checked every cycle plus literal expectations.
module tb_phv_queue_merger;

    localparam int W     = 1024;
    localparam int DEPTH = 4;

    logic axis_clk = 1'b0;
    logic areset;
    logic [W-1:0] pin [4];
    logic [3:0]   vin;
    logic         m_phv_ready;
    logic         phv_fifo_ready_0, phv_fifo_ready_1, phv_fifo_ready_2, phv_fifo_ready_3;
    logic [W-1:0] m_phv;
    logic [1:0]   m_queue_id;
    logic         m_phv_valid;
    logic [15:0]  drop_cnt_0, drop_cnt_1, drop_cnt_2, drop_cnt_3;

    logic [3:0]   rdy;
    logic [15:0]  dcnt [4];
    assign rdy     = {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0};
    assign dcnt[0] = drop_cnt_0;
    assign dcnt[1] = drop_cnt_1;
    assign dcnt[2] = drop_cnt_2;
    assign dcnt[3] = drop_cnt_3;

    phv_queue_merger #(
        .PHV_LEN       (W),
        .C_NUM_QUEUES  (4),
        .FIFO_DEPTH    (DEPTH),
        .QUEUE_BIT_OFF (141)
    ) dut (
        .axis_clk         (axis_clk),
        .areset           (areset),
        .phv_in_0         (pin[0]),
        .phv_in_1         (pin[1]),
        .phv_in_2         (pin[2]),
        .phv_in_3         (pin[3]),
        .phv_in_valid_0   (vin[0]),
        .phv_in_valid_1   (vin[1]),
        .phv_in_valid_2   (vin[2]),
        .phv_in_valid_3   (vin[3]),
        .phv_fifo_ready_0 (phv_fifo_ready_0),
        .phv_fifo_ready_1 (phv_fifo_ready_1),
        .phv_fifo_ready_2 (phv_fifo_ready_2),
        .phv_fifo_ready_3 (phv_fifo_ready_3),
        .m_phv            (m_phv),
        .m_queue_id       (m_queue_id),
        .m_phv_valid      (m_phv_valid),
        .m_phv_ready      (m_phv_ready),
        .drop_cnt_0       (drop_cnt_0),
        .drop_cnt_1       (drop_cnt_1),
        .drop_cnt_2       (drop_cnt_2),
        .drop_cnt_3       (drop_cnt_3)
    );

    always #5 axis_clk = ~axis_clk;

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_phv(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got low64 %h, expected low64 %h (full PHV differs)", name, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] mk(input int ch, input int n, input logic [3:0] qf);
        logic [W-1:0] v;
        for (int i = 0; i < 32; i++)
            v[i*32 +: 32] = (32'(ch) * 32'h1000_0000) ^ (32'(n) * 32'h0101_0101) ^ 32'(i);
        v[141 +: 4] = qf;
        return v;
    endfunction

    // Reference model: per-channel queues, output slot and round-robin pointer.
    logic [W-1:0] mq [4][$];
    logic         mov   = 1'b0;
    logic [1:0]   mqid  = '0;
    logic [W-1:0] mphv  = '0;
    int           mdrop [4];
    int           mlg   = 3;
    logic         mvalid = 1'b0;

    // Inputs are stable from negedge to the following posedge, so the model steps here.
    initial begin
        forever begin
            @(negedge axis_clk);
            if (mvalid) begin
                check("m_phv_valid", {63'd0, m_phv_valid}, {63'd0, mov});
                check("m_queue_id", {62'd0, m_queue_id}, {62'd0, mqid});
                check_phv("m_phv", m_phv, mphv);
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("ready_%0d", k), {63'd0, rdy[k]},
                          {63'd0, (mq[k].size() <= DEPTH - 2)});
                    check($sformatf("drop_cnt_%0d", k), {48'd0, dcnt[k]}, 64'(mdrop[k]));
                end
            end
            if (areset) begin
                for (int k = 0; k < 4; k++) begin
                    mq[k].delete();
                    mdrop[k] = 0;
                end
                mov = 1'b0; mqid = '0; mphv = '0; mlg = 3; mvalid = 1'b1;
            end else begin
                int g;
                logic any, ld;
                any = 1'b0;
                g = -1;
                for (int i = 1; i <= 4; i++) begin
                    if (g < 0 && mq[(mlg + i) % 4].size() > 0) g = (mlg + i) % 4;
                end
                any = (g >= 0);
                ld = any && (!mov || m_phv_ready);
                if (ld) begin
                    mphv = mq[g].pop_front();
                    mqid = 2'(g);
                    mov  = 1'b1;
                    mlg  = g;
                end else if (m_phv_ready) begin
                    mov = 1'b0;
                end
                for (int k = 0; k < 4; k++) begin
                    if (vin[k]) begin
                        if (mq[k].size() < DEPTH) mq[k].push_back(pin[k]);
                        else if (mdrop[k] < 65535) mdrop[k]++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge axis_clk);
        #2;
    endtask

    task automatic idle_inputs();
        vin = '0;
        for (int k = 0; k < 4; k++) pin[k] = '0;
    endtask

    initial begin
        areset = 1'b1;
        m_phv_ready = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        areset = 1'b0;
        check("reset valid", {63'd0, m_phv_valid}, 64'd0);
        check("reset queue_id", {62'd0, m_queue_id}, 64'd0);
        check("reset ready", {60'd0, rdy}, 64'hF);
        check("reset drop_cnt_3", {48'd0, drop_cnt_3}, 64'd0);

        // Multicast on all channels: drained 0,1,2,3.
        vin = 4'hF;
        for (int k = 0; k < 4; k++) pin[k] = mk(k, 0, 4'hF);
        cyc();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("mcast valid %0d", i), {63'd0, m_phv_valid}, 64'd1);
            check($sformatf("mcast qid %0d", i), {62'd0, m_queue_id}, 64'(i));
        end
        cyc();
        check("mcast idle", {63'd0, m_phv_valid}, 64'd0);

        // Single PHV on channel 2.
        vin[2] = 1'b1;
        pin[2] = {128{8'hA5}};
        cyc();
        idle_inputs();
        check("single not yet", {63'd0, m_phv_valid}, 64'd0);
        cyc();
        check("single valid", {63'd0, m_phv_valid}, 64'd1);
        check("single qid", {62'd0, m_queue_id}, 64'd2);
        check_phv("single phv", m_phv, {128{8'hA5}});
        cyc();
        check("single one cycle", {63'd0, m_phv_valid}, 64'd0);

        // Backpressure on channel 1: the output register absorbs the first PHV.
        m_phv_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            vin[1] = 1'b1;
            pin[1] = mk(1, n, 4'b0010);
            cyc();
            check($sformatf("bp ready after write %0d", n + 1), {63'd0, phv_fifo_ready_1},
                  {63'd0, n < 3});
        end
        idle_inputs();
        check("bp no drop", {48'd0, drop_cnt_1}, 64'd0);
        m_phv_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("bp drain valid %0d", n), {63'd0, m_phv_valid}, 64'd1);
            check_phv($sformatf("bp drain phv %0d", n), m_phv, mk(1, n, 4'b0010));
            cyc();
        end
        check("bp drained", {63'd0, m_phv_valid}, 64'd0);

        // Overflow on channel 3: five held, two dropped.
        m_phv_ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            vin[3] = 1'b1;
            pin[3] = mk(3, n, 4'b1000);
            cyc();
        end
        idle_inputs();
        check("ovf drop_cnt_3", {48'd0, drop_cnt_3}, 64'd2);
        m_phv_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            check_phv($sformatf("ovf drain phv %0d", n), m_phv, mk(3, n, 4'b1000));
            cyc();
        end
        check("ovf drained", {63'd0, m_phv_valid}, 64'd0);

        // Fairness between channels 0 and 3.
        for (int n = 0; n < 9; n++) begin
            vin = 4'b1001;
            pin[0] = mk(0, 100 + n, 4'b0001);
            pin[3] = mk(3, 100 + n, 4'b1000);
            cyc();
            if (n > 0) check($sformatf("fair qid %0d", n), {62'd0, m_queue_id},
                             (n % 2 == 1) ? 64'd0 : 64'd3);
        end
        idle_inputs();
        repeat (12) cyc();
        check("fair drained", {63'd0, m_phv_valid}, 64'd0);

        // Reset with PHVs queued; inputs during reset are ignored.
        m_phv_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            vin[0] = 1'b1;
            pin[0] = mk(0, 200 + n, 4'b0001);
            cyc();
        end
        idle_inputs();
        areset = 1'b1;
        vin[2] = 1'b1;
        pin[2] = mk(2, 300, 4'b0100);
        cyc();
        areset = 1'b0;
        idle_inputs();
        check("rst mid valid", {63'd0, m_phv_valid}, 64'd0);
        check("rst mid ready", {60'd0, rdy}, 64'hF);
        check("rst mid drop_cnt_0", {48'd0, drop_cnt_0}, 64'd0);
        m_phv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("rst no stale %0d", i), {63'd0, m_phv_valid}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
